// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - ID-stage fields in, forwarding/stall controls out
interface fwd_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             branch_flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             stall;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write, id_mem_read, branch_flush,
    input  ForwardA, ForwardB, stall, id_ex_bubble, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_reg_write, id_mem_read, branch_flush,
    output ForwardA, ForwardB, stall, id_ex_bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - MIPS forwarding selects and load-use/RAW stall control
// Optional feature macro: FWD_HAZARD_FORWARDING_EN (undefined: stall on every RAW, no forwarding)
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_ctrl_if.slave  bus
);

`ifdef FWD_HAZARD_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [4:0]       ex_dest, mem_dest;
  logic             ex_rw, ex_mr, mem_rw;
  logic [1:0]       fa_q, fb_q, fa_next, fb_next;
  logic [CNT_W-1:0] cnt_q;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;
  logic             hazard, stall, bubble;

  function automatic logic hit(input logic used, input logic [4:0] r,
                               input logic rw, input logic [4:0] dest);
    return used && (r != 5'd0) && rw && (dest == r);
  endfunction

  always_comb begin
    rs_ex  = hit(bus.id_use_rs, bus.id_rs, ex_rw, ex_dest);
    rt_ex  = hit(bus.id_use_rt, bus.id_rt, ex_rw, ex_dest);
    rs_mem = hit(bus.id_use_rs, bus.id_rs, mem_rw, mem_dest);
    rt_mem = hit(bus.id_use_rt, bus.id_rt, mem_rw, mem_dest);
    // Without forwarding any in-flight producer blocks the consumer until it reaches WB.
    hazard = FWD_EN ? (ex_mr && (rs_ex || rt_ex))
                    : (rs_ex || rt_ex || rs_mem || rt_mem);
    stall  = hazard && !bus.branch_flush;
    bubble = stall || bus.branch_flush;
    fa_next = rs_ex ? 2'b10 : (rs_mem ? 2'b01 : 2'b00);
    fb_next = rt_ex ? 2'b10 : (rt_mem ? 2'b01 : 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_dest  <= 5'd0;
      ex_rw    <= 1'b0;
      ex_mr    <= 1'b0;
      mem_dest <= 5'd0;
      mem_rw   <= 1'b0;
      fa_q     <= 2'b00;
      fb_q     <= 2'b00;
      cnt_q    <= '0;
    end else begin
      mem_dest <= ex_dest;
      mem_rw   <= ex_rw;
      if (bubble) begin
        ex_dest <= 5'd0;
        ex_rw   <= 1'b0;
        ex_mr   <= 1'b0;
        fa_q    <= 2'b00;
        fb_q    <= 2'b00;
      end else begin
        ex_dest <= bus.id_dest;
        ex_rw   <= bus.id_reg_write;
        ex_mr   <= bus.id_mem_read;
        fa_q    <= fa_next;
        fb_q    <= fb_next;
      end
      if (stall && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ForwardA     = FWD_EN ? fa_q : 2'b00;
  assign bus.ForwardB     = FWD_EN ? fb_q : 2'b00;
  assign bus.stall        = stall;
  assign bus.id_ex_bubble = bubble;
  assign bus.stall_count  = cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller that generates the `ForwardA`/`ForwardB` select codes and the stall and bubble controls consumed by the EX stage and the front end of the 5-stage MIPS pipeline. It sits beside the ID stage and sees each instruction's operand and destination fields as it leaves ID. It keeps its own shadow copies of the EX and MEM destination state. It presents forwarding selects, registered and aligned to the cycle the instruction occupies EX.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating stall counter

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `id_rs`  in  5  rs field of instruction in ID
- `id_rt`  in  5  rt field of instruction in ID
- `id_use_rs`  in  1  instruction in ID reads rs
- `id_use_rt`  in  1  instruction in ID reads rt
- `id_dest`  in  5  destination register of instruction in ID (rd or rt, already selected)
- `id_reg_write`  in  1  instruction in ID writes `id_dest`
- `id_mem_read`  in  1  instruction in ID is a load
- `branch_flush`  in  1  EX resolved a taken branch/jump; instruction in ID is squashed
- `ForwardA`  out  2  EX operand-A select: 00 regfile, 10 MEM ALU result, 01 WB result
- `ForwardB`  out  2  EX operand-B select, same encoding
- `stall`  out  1  hold PC and IF/ID this cycle
- `id_ex_bubble`  out  1  load ID/EX with a NOP this cycle
- `stall_count`  out  `CNT_W`  number of stall cycles since reset, saturating

## Operation
- Shadow state, updated every clock: the EX entry is `{ex_dest, ex_rw, ex_mr}`, and the MEM entry is `{mem_dest, mem_rw}`.
- MEM entry <= EX entry.
- EX entry <= ID fields, except when `id_ex_bubble` is high. In that case the EX entry <= all zero.
- A match on operand X (rs or rt) requires all of:
  - X is used;
  - X != 0;
  - the entry's register-write bit is set;
  - the entry's dest == X.
- Next-forward for operand X:
  - 10 if it matches the EX entry;
  - else 01 if it matches the MEM entry;
  - else 00.
  - The EX entry always takes priority.
- `ForwardA`/`ForwardB` <= next-forward(rs)/next-forward(rt), except when `id_ex_bubble` is high. In that case they load 00.
- Load-use hazard: `ex_mr` is set and either operand matches the EX entry.
- `stall` = load-use hazard AND NOT `branch_flush`. A flush always wins, because the dependent instruction is being discarded.
- `id_ex_bubble` = `stall` OR `branch_flush`.
- `stall_count` increments on each clock edge where `stall` is high, and holds at all-ones.
- Register $0 never causes forwarding or stalls.
- The WB-to-ID distance needs no handling: the regfile writes in the first half-cycle.

## Timing
- Reset values (asynchronous):
  - `ForwardA` = `ForwardB` = 00;
  - both shadow entries zero, so `stall` = `id_ex_bubble` = 0;
  - `stall_count` = 0.
- `ForwardA`/`ForwardB` are registered with 1-cycle latency from ID. They are valid for the whole cycle the instruction is in EX.
- `stall` and `id_ex_bubble` are combinational, in the same cycle as detection.
- Load-use costs exactly 1 stall cycle:
  - the bubble enters EX, and the load moves to MEM;
  - in the next cycle the consumer re-presents in ID and receives 01 in its EX cycle.
- Simultaneous `branch_flush` and hazard: no stall, bubble inserted, counter unchanged.
- Reset asserted mid-stall: all state clears immediately, and `stall` drops in the same cycle.

## Configuration
- `FWD_HAZARD_FORWARDING_EN` defined: behaviour as above.
- `FWD_HAZARD_FORWARDING_EN` undefined:
  - `ForwardA`/`ForwardB` are held at 00;
  - `stall` = (match on EX entry OR match on MEM entry) AND NOT `branch_flush`, regardless of `ex_mr`;
  - a back-to-back dependency costs 2 stall cycles, and distance 2 costs 1.
  - Counter and bubble rules are unchanged.

## Test plan
- `add r3` then `sub` using `r3` as rs next cycle -> `ForwardA`=10 and `ForwardB`=00 during `sub`'s EX cycle, no stall.
- `add r3`, `nop`, then an instruction using `r3` as rt -> `ForwardB`=01 in its EX cycle.
- `lw r4` then `add` using `r4` as rt -> `stall`=1 and `id_ex_bubble`=1 for exactly 1 cycle, `stall_count` 0->1, then `ForwardB`=01 in `add`'s EX cycle.
- Producer with dest `r0`, or with `id_reg_write`=0, followed by a consumer of `r0`/that register -> Forward 00, no stall. Two consecutive producers of `r5` then a consumer -> 10 (EX priority).
- Load-use hazard with `branch_flush`=1 in the same cycle -> `stall`=0, `id_ex_bubble`=1, `stall_count` unchanged. Assert `rst` during a stall -> all outputs 00/0 immediately.
- Macro undefined: `add r3` then a dependent `sub` -> `stall` high for 2 cycles, Forward 00 throughout, `stall_count`=2.
